board_eval: RTL and testbench
=============================

Name: board_eval

Overview:
- Reader-side companion to the move generators. Move generators write N candidate boards, each 64 consecutive words, into SDRAM.
- board_eval reads those boards back over an Avalon-MM master and computes a material score for each.
- It reports the index and score of the best board for the requested side to the CPU over an Avalon-MM slave.
- It sits on the same CPU and SDRAM interconnect as the generators.

Parameters:
- NUM_SQ, 64, squares per board; the address stride between boards.
- SCORE_W, 16, width of the internal signed score accumulator.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- slave_waitrequest  out  1  stalls CPU reads of result registers while busy
- slave_address  in  4  register select
- slave_read  in  1  CPU read strobe
- slave_readdata  out  32  register read data
- slave_write  in  1  CPU write strobe
- slave_writedata  in  32  register write data
- master_waitrequest  in  1  SDRAM not ready to accept the read command
- master_address  out  32  SDRAM word address
- master_read  out  1  SDRAM read request
- master_readdata  in  32  SDRAM read data; bits [7:0] hold the signed piece code
- master_readdatavalid  in  1  master_readdata is valid this cycle

Behaviour:
- Clock and reset:
  - one clock, clk; reset rst is synchronous and active-high.
  - On reset: master_read=0, master_address=0, state=IDLE, busy=0.
  - Also on reset: best_idx=0xFFFFFFFF, best_score=0, and base, num, side registers are all cleared.
- Register map, writes:
  - addr 1: base (32b).
  - addr 2: num_boards, bits [7:0] only.
  - addr 3: side, where writedata[31]=0 means WHITE (+1) and writedata[31]=1 means BLACK (-1).
  - addr 0: start.
  - Writes while busy are accepted and discarded.
- Register map, reads:
  - addr 0: best_idx.
  - addr 1: best_score, sign-extended to 32b.
  - addr 2: {31'b0, busy}.
  - Other addresses read 0.
- slave_waitrequest = busy & slave_read & (slave_address==0 | slave_address==1). It is combinational; status reads never stall; writes never stall.
- Piece weights by |code[7:0]| (code is signed 8b):
  - 0 and 6 (empty, king) -> 0; 1 -> 1; 2 -> 3; 3 -> 3; 4 -> 5; 5 -> 9.
  - Any other magnitude -> 0.
  - Contribution is +weight for a positive code and -weight for a negative code.
- Board score = side * sum of contributions over the 64 squares, in SCORE_W signed arithmetic (no overflow possible: |max| = 576).
- FSM:
  - IDLE: on a start write, clear board index b=0, square count sq=0, acc=0, best_idx=0xFFFFFFFF, best_score=0.
    - If num_boards==0, go to IDLE with busy=0 (result stays 0xFFFFFFFF).
    - Otherwise set busy=1 and go to REQ.
  - REQ: master_read=1, master_address = base + b*64 + sq.
    - Hold address and read stable while master_waitrequest=1.
    - On the first cycle with master_waitrequest=0, deassert master_read next cycle and go to WAIT_DATA.
  - WAIT_DATA: on master_readdatavalid, acc += contribution(readdata[7:0]).
    - If sq==63, go to SCORE; else sq++ and go to REQ.
    - readdatavalid outside WAIT_DATA is ignored.
  - SCORE: s = side*acc.
    - If b==0 or s > best_score (strictly greater), set best_score=s and best_idx=b. First maximum wins ties.
    - Then clear acc and sq. If b==num_boards-1, go to IDLE with busy=0; else b++ and go to REQ.
- Only one read is outstanding at a time. Minimum cost per square is 2 cycles (REQ, WAIT_DATA), plus 1 SCORE cycle per board.
- Address arithmetic is 32b and wraps silently.
- Reset mid-operation drops master_read in the same edge and returns to IDLE. A late readdatavalid is then ignored.
- A stalled CPU result read completes in the cycle after busy falls, with final values.

Decomposition:
- chess_pkg holds:
  - colour constants WHITE=+1, BLACK=-1, EMPTY=0;
  - piece-code constants 1..6;
  - the weight table;
  - slave register address constants;
  - the FSM state enum.
- Sub-module piece_weight: combinational, signed 8b code in, signed SCORE_W contribution out. It is shared with future evaluators.

Test Plan:
- Single board at base 0x1000: all empty except code +5 at square 3 and -4 at square 60; side=WHITE; num=1 -> best_idx=0, best_score=4. Exactly 64 reads at 0x1000..0x103F in order.
- Three boards with white-relative scores +1, +9, +9; side=WHITE -> best_idx=1, best_score=9 (tie keeps first).
- Same three boards, side=BLACK -> best_idx=0, best_score=-1.
- num_boards=0 then start -> busy never set, addr 0 reads 0xFFFFFFFF, addr 1 reads 0, zero master reads issued.
- Random master_waitrequest (0-3 cycles) and readdatavalid latency (1-5 cycles); CPU reads addr 0 right after start -> slave_waitrequest held until done. Result matches the no-stall run, and master_address stays stable during every stall.
- Assert rst during board 1, square 20 -> master_read=0 the next cycle, busy=0, best_idx=0xFFFFFFFF. A readdatavalid pulse arriving after reset changes nothing.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: shared chess constants, piece weights, register map and evaluator FSM states
package chess_pkg;
    localparam int WHITE = 1;
    localparam int BLACK = -1;
    localparam int EMPTY = 0;
    localparam int PAWN   = 1;
    localparam int KNIGHT = 2;
    localparam int BISHOP = 3;
    localparam int ROOK   = 4;
    localparam int QUEEN  = 5;
    localparam int KING   = 6;
    // Indexed by piece magnitude; kings and unknown codes score nothing.
    localparam int WEIGHT [8] = '{0, 1, 3, 3, 5, 9, 0, 0};
    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_BASE  = 4'd1;
    localparam logic [3:0] REG_NUM   = 4'd2;
    localparam logic [3:0] REG_SIDE  = 4'd3;
    localparam logic [3:0] REG_IDX   = 4'd0;
    localparam logic [3:0] REG_SCORE = 4'd1;
    localparam logic [3:0] REG_BUSY  = 4'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, SCORE} state_t;
endpackage

// File: rtl/board_eval_if.sv
// board_eval_if: CPU-side Avalon-MM slave and SDRAM-side Avalon-MM master signals of the evaluator
// slave modport: evaluator view of the CPU register port; master modport: evaluator view of the SDRAM read port
interface board_eval_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    modport slave (
        output slave_waitrequest, slave_readdata,
        input  slave_address, slave_read, slave_write, slave_writedata
    );
    modport master (
        output master_address, master_read,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );
endinterface

// File: rtl/piece_weight.sv
// piece_weight: signed material contribution of one signed 8-bit piece code
// ports: code (signed piece code in), contrib (signed SCORE_W contribution out)
module piece_weight
    import chess_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic signed [7:0]         code,
    output logic signed [SCORE_W-1:0] contrib
);
    logic [7:0]                mag;
    logic signed [SCORE_W-1:0] w;
    always_comb begin
        mag     = code[7] ? 8'(-code) : code;
        w       = mag[7:3] == 5'd0 ? SCORE_W'(WEIGHT[mag[2:0]]) : '0;
        contrib = code[7] ? -w : w;
    end
endmodule

// File: rtl/board_eval.sv
// board_eval: reads candidate boards from SDRAM, scores material, reports best board to the CPU
// ports: clk, rst (sync active-high); cpu (register slave: base/num/side/start, best_idx/best_score/busy);
//        mem (SDRAM read master, one outstanding word read at a time)
module board_eval
    import chess_pkg::*;
#(
    parameter int NUM_SQ  = 64,
    parameter int SCORE_W = 16
) (
    input  logic clk,
    input  logic rst,
    board_eval_if.slave  cpu,
    board_eval_if.master mem
);
    localparam int SQ_W = $clog2(NUM_SQ);
    state_t                    state, state_n;
    logic [31:0]               base, best_idx;
    logic [7:0]                num, b;
    logic [SQ_W-1:0]           sq;
    logic                      side_black, busy, wr_ok, start, last_sq, last_b, better;
    logic signed [SCORE_W-1:0] acc, s, contrib, best_score;
    logic                      unused_hi;

    piece_weight #(.SCORE_W(SCORE_W)) u_weight (.code(mem.master_readdata[7:0]), .contrib(contrib));

    always_comb begin
        unused_hi = ^mem.master_readdata[31:8];
        busy      = state != IDLE;
        wr_ok     = cpu.slave_write && !busy;
        start     = wr_ok && cpu.slave_address == REG_START;
        last_sq   = sq == SQ_W'(NUM_SQ - 1);
        last_b    = b == num - 8'd1;
        s         = side_black ? -acc : acc;
        better    = b == 8'd0 || s > best_score;
        state_n   = state == IDLE      ? (start && num != 8'd0 ? REQ : IDLE)
                  : state == REQ       ? (mem.master_waitrequest ? REQ : WAIT_DATA)
                  : state == WAIT_DATA ? (mem.master_readdatavalid ? (last_sq ? SCORE : REQ) : WAIT_DATA)
                  : (last_b ? IDLE : REQ);
        mem.master_read    = state == REQ;
        mem.master_address = base + 32'(b) * 32'(NUM_SQ) + 32'(sq);
        // Only result registers stall; they would be stale mid-run.
        cpu.slave_waitrequest = busy && cpu.slave_read &&
                                (cpu.slave_address == REG_IDX || cpu.slave_address == REG_SCORE);
        cpu.slave_readdata = cpu.slave_address == REG_IDX   ? best_idx
                           : cpu.slave_address == REG_SCORE ? 32'(best_score)
                           : cpu.slave_address == REG_BUSY  ? {31'b0, busy}
                           : '0;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            num        <= '0;
            side_black <= 1'b0;
            best_idx   <= '1;
            best_score <= '0;
            acc        <= '0;
            b          <= '0;
            sq         <= '0;
        end else begin
            if (wr_ok && cpu.slave_address == REG_BASE) base <= cpu.slave_writedata;
            if (wr_ok && cpu.slave_address == REG_NUM) num <= cpu.slave_writedata[7:0];
            if (wr_ok && cpu.slave_address == REG_SIDE) side_black <= cpu.slave_writedata[31];
            if (start) begin
                b          <= '0;
                sq         <= '0;
                acc        <= '0;
                best_idx   <= '1;
                best_score <= '0;
            end
            if (state == WAIT_DATA && mem.master_readdatavalid) begin
                acc <= acc + contrib;
                if (!last_sq) sq <= sq + SQ_W'(1);
            end
            if (state == SCORE) begin
                if (better) begin
                    best_score <= s;
                    best_idx   <= 32'(b);
                end
                acc <= '0;
                sq  <= '0;
                if (!last_b) b <= b + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: directed and randomized checks of board_eval against a material-score reference model
module tb_board_eval;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_eval_if bus ();
    board_eval dut (.clk(clk), .rst(rst), .cpu(bus), .mem(bus));

    int checks = 0;
    int errors = 0;
    logic signed [7:0] brd [4][64];
    logic [31:0] tb_base = 0;
    int tb_nb = 0;
    bit stall_en = 0;
    int nreads = 0;
    int stall_viol = 0;
    int inject = 0;
    logic [31:0] acc_q [$];
    logic pr = 0, pw = 0, in_req = 0, pend = 0;
    int st = 0, lat = 0;
    logic [31:0] held = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] code_at(input logic [31:0] a);
        logic [31:0] off;
        off = a - tb_base;
        if (off < 32'(tb_nb * 64)) return brd[int'(off >> 6)][int'(off[5:0])];
        return 8'd0;
    endfunction

    function automatic int wt(input int c);
        int m;
        int w;
        m = c < 0 ? -c : c;
        case (m)
            1: w = 1;
            2, 3: w = 3;
            4: w = 5;
            5: w = 9;
            default: w = 0;
        endcase
        return c < 0 ? -w : w;
    endfunction

    function automatic int board_score(input int i, input bit blk);
        int sum;
        sum = 0;
        for (int j = 0; j < 64; j++) sum += wt(int'(brd[i][j]));
        return blk ? -sum : sum;
    endfunction

    // SDRAM model: random accept stall, random read latency, one read at a time.
    initial begin
        bus.master_waitrequest   = 0;
        bus.master_readdatavalid = 0;
        bus.master_readdata      = 0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 0;
            if (rst) begin
                pr = 0; pw = 0; in_req = 0; pend = 0;
                bus.master_waitrequest = 0;
            end else begin
                if (pr && !pw) begin
                    pend = 1;
                    in_req = 0;
                    lat = stall_en ? int'($urandom_range(1, 5)) : 1;
                    nreads++;
                    acc_q.push_back(held);
                end
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        pend = 0;
                        bus.master_readdatavalid = 1;
                        bus.master_readdata = {24'($urandom), code_at(held)};
                    end
                end
                if (inject > 0) begin
                    bus.master_readdatavalid = 1;
                    bus.master_readdata = 32'h0000_0005;
                    inject = 0;
                end
                if (bus.master_read) begin
                    if (!in_req) begin
                        in_req = 1;
                        held = bus.master_address;
                        st = stall_en ? int'($urandom_range(0, 3)) : 0;
                    end else if (bus.master_address !== held) stall_viol++;
                    bus.master_waitrequest = st > 0;
                    if (st > 0) st--;
                end else bus.master_waitrequest = 0;
                pr = bus.master_read;
                pw = bus.master_waitrequest;
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_writedata = d;
        bus.slave_write = 1;
        @(negedge clk);
        bus.slave_write = 0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int stalls);
        stalls = 0;
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read = 1;
        #1;
        while (bus.slave_waitrequest === 1'b1 && stalls < 20000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 20000) check("read_bound", 32'(bus.slave_waitrequest), 0);
        d = bus.slave_readdata;
        @(posedge clk);
        #1;
        bus.slave_read = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        int s;
        cpu_read(a, d, s);
    endtask

    task automatic clear_boards();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++) brd[i][j] = 0;
    endtask

    task automatic random_boards();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++)
                brd[i][j] = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'($urandom_range(0, 12)) - 8'sd6;
    endtask

    task automatic run(input string tag, input logic [31:0] base, input int nb, input bit blk, input bit stall);
        logic [31:0] d;
        int stalls, n, bad, ei, es, s;
        tb_base = base;
        tb_nb = nb;
        stall_en = stall;
        nreads = 0;
        stall_viol = 0;
        acc_q.delete();
        cpu_write(4'd1, base);
        cpu_write(4'd2, 32'(nb));
        cpu_write(4'd3, blk ? 32'h8000_0000 : 32'h0);
        cpu_write(4'd0, 32'h0);
        ei = -1;
        es = 0;
        for (int i = 0; i < nb; i++) begin
            s = board_score(i, blk);
            if (i == 0 || s > es) begin
                es = s;
                ei = i;
            end
        end
        if (stall) begin
            cpu_read(4'd0, d, stalls);
            check({tag, "_stalled"}, 32'(stalls != 0), 1);
            check({tag, "_idx"}, d, 32'(ei));
        end else begin
            n = 0;
            do begin
                rd(4'd2, d);
                n++;
            end while (d[0] && n < 5000);
            check({tag, "_idle"}, d, 0);
            rd(4'd0, d);
            check({tag, "_idx"}, d, 32'(ei));
        end
        rd(4'd1, d);
        check({tag, "_score"}, d, 32'(es));
        rd(4'd2, d);
        check({tag, "_busy_end"}, d, 0);
        check({tag, "_nreads"}, 32'(nreads), 32'(nb * 64));
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] !== base + 32'(i)) bad++;
        check({tag, "_addr_order"}, 32'(bad), 0);
        check({tag, "_addr_stable"}, 32'(stall_viol), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] target;
        int n;
        bit blk;
        int nb;
        bus.slave_address = 0;
        bus.slave_read = 0;
        bus.slave_write = 0;
        bus.slave_writedata = 0;
        clear_boards();
        repeat (3) @(negedge clk);
        #1;
        check("rst_master_read", 32'(bus.master_read), 0);
        check("rst_master_address", bus.master_address, 0);
        rst = 0;
        rd(4'd2, d);
        check("rst_busy", d, 0);
        rd(4'd0, d);
        check("rst_best_idx", d, 32'hFFFF_FFFF);
        rd(4'd1, d);
        check("rst_best_score", d, 0);
        rd(4'd5, d);
        check("unmapped_read", d, 0);

        clear_boards();
        brd[0][3] = 5;
        brd[0][60] = -4;
        run("single", 32'h0000_1000, 1, 0, 0);
        rd(4'd1, d);
        check("single_score_value", d, 32'd4);

        clear_boards();
        brd[0][0] = 1;
        brd[1][10] = 5;
        brd[2][5] = 4;
        brd[2][6] = 4;
        brd[2][7] = -1;
        run("three_white", 32'h0000_4000, 3, 0, 0);
        run("three_black", 32'h0000_4000, 3, 1, 0);
        rd(4'd1, d);
        check("three_black_neg", d, 32'hFFFF_FFFF);

        tb_nb = 0;
        nreads = 0;
        cpu_write(4'd2, 32'h0);
        cpu_write(4'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(4'd2, d);
            check("zero_busy", d, 0);
        end
        rd(4'd0, d);
        check("zero_best_idx", d, 32'hFFFF_FFFF);
        rd(4'd1, d);
        check("zero_best_score", d, 0);
        check("zero_nreads", 32'(nreads), 0);

        for (int r = 0; r < 3; r++) begin
            random_boards();
            blk = 1'($urandom);
            nb = int'($urandom_range(1, 4));
            target = r == 0 ? 32'hFFFF_FFE0 : $urandom;
            run("rand_nostall", target, nb, blk, 0);
            run("rand_stall", target, nb, blk, 1);
        end

        clear_boards();
        brd[0][1] = 5;
        tb_base = 32'h0000_2000;
        tb_nb = 3;
        stall_en = 0;
        cpu_write(4'd1, 32'h0000_2000);
        cpu_write(4'd2, 32'd3);
        cpu_write(4'd3, 32'h0);
        cpu_write(4'd0, 32'h0);
        target = 32'h0000_2000 + 32'd64 + 32'd20;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(bus.master_read && bus.master_address == target) && n < 3000);
        if (n >= 3000) check("reach_b1_sq20", bus.master_address, target);
        rst = 1;
        @(posedge clk);
        #1;
        check("midrst_master_read", 32'(bus.master_read), 0);
        @(negedge clk);
        rst = 0;
        rd(4'd2, d);
        check("midrst_busy", d, 0);
        rd(4'd0, d);
        check("midrst_best_idx", d, 32'hFFFF_FFFF);
        inject = 1;
        repeat (4) @(negedge clk);
        #1;
        check("late_rdv_master_read", 32'(bus.master_read), 0);
        rd(4'd2, d);
        check("late_rdv_busy", d, 0);
        rd(4'd0, d);
        check("late_rdv_best_idx", d, 32'hFFFF_FFFF);
        rd(4'd1, d);
        check("late_rdv_best_score", d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
